// File: rtl/shift_pkg.sv
// shift_pkg: shift modes and FSM state encoding shared by the iterative shifter.
`default_nettype none

package shift_pkg;

  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRL = 2'b01;
  localparam logic [1:0] MODE_SRA = 2'b10;
  localparam logic [1:0] MODE_ROL = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/shift_stage.sv
// shift_stage: one barrel-network stage that shifts by 2^K in the selected mode when enabled.
`default_nettype none

module shift_stage #(
  parameter int W = 32,
  parameter int K = 0
) (
  input  logic [W-1:0] in,
  input  logic         en,
  input  logic [1:0]   mode,
  input  logic         sign,
  output logic [W-1:0] out
);
  import shift_pkg::*;

  localparam int S = 1 << K;

  always_comb begin
    out = in;
    if (en) begin
      case (mode)
        MODE_SLL: out = {in[W-1-S:0], {S{1'b0}}};
        MODE_SRL: out = {{S{1'b0}}, in[W-1:S]};
        MODE_SRA: out = {{S{sign}}, in[W-1:S]};
        default:  out = {in[W-1-S:0], in[W-1:W-S]};
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/shift_iter.sv
// shift_iter: multicycle shifter (SLL/SRL/SRA/ROL) applying SPC barrel stages per cycle,
// with valid/ready handshakes on both sides and a synchronous abort.
`default_nettype none

module shift_iter #(
  parameter int W       = 32,
  parameter int SPC     = 1,
  parameter int SHAMT_W = $clog2(W)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_mode,
  input  logic               abort,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W-1:0]       out_data,
  output logic               busy
);
  import shift_pkg::*;

  localparam int NCYC  = (SHAMT_W + SPC - 1) / SPC;
  localparam int CNT_W = (NCYC > 1) ? $clog2(NCYC) : 1;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [W-1:0]       data;
  logic [SHAMT_W-1:0] shamt;
  logic [1:0]         mode;
  logic               sign;
  logic [W-1:0]       result;
  logic               last;

  assign last = (cnt == CNT_W'(NCYC - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (abort)     state_nxt = IDLE;
        else if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (abort || out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // out_data is only written on the final shift cycle so partial values never reach it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= '0;
      data     <= '0;
      shamt    <= '0;
      mode     <= '0;
      sign     <= 1'b0;
      out_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            data  <= in_data;
            shamt <= in_shamt;
            mode  <= in_mode;
            sign  <= in_data[W-1];
            cnt   <= '0;
          end
        end
        SHIFT: begin
          if (!abort) begin
            data <= result;
            cnt  <= cnt + CNT_W'(1);
            if (last) out_data <= result;
          end
        end
        default: ;
      endcase
    end
  end

  // Chain position j handles stage k = cnt*SPC + j; each candidate stage is fixed-K and the counter picks one.
  for (genvar j = 0; j < SPC; j++) begin : g_pos
    logic [W-1:0] din;
    logic [W-1:0] dout;
    logic [W-1:0] cand [NCYC];

    if (j == 0) begin : g_first
      assign din = data;
    end else begin : g_next
      assign din = g_pos[j-1].dout;
    end

    for (genvar c = 0; c < NCYC; c++) begin : g_cyc
      localparam int K = c * SPC + j;
      if (K < SHAMT_W) begin : g_stage
        shift_stage #(.W(W), .K(K)) u_stage (
          .in   (din),
          .en   (shamt[K]),
          .mode (mode),
          .sign (sign),
          .out  (cand[c])
        );
      end else begin : g_pass
        assign cand[c] = din;
      end
    end

    always_comb begin
      dout = din;
      for (int c = 0; c < NCYC; c++) begin
        if (cnt == CNT_W'(c)) dout = cand[c];
      end
    end
  end

  assign result = g_pos[SPC-1].dout;

endmodule

`default_nettype wire

// File: tb/tb_shift_iter.sv
// tb_shift_iter: scoreboard bench for shift_iter, directed tests on an SPC=1 instance and
// randomized back-to-back traffic on an SPC=5 instance.
`default_nettype none

module tb_shift_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // SPC=1 instance
  logic        rst_n1, in_valid1, in_ready1, abort1, out_valid1, out_ready1, busy1;
  logic [31:0] in_data1, out_data1;
  logic [4:0]  in_shamt1;
  logic [1:0]  in_mode1;
  // SPC=5 instance
  logic        rst_n5, in_valid5, in_ready5, abort5, out_valid5, out_ready5, busy5;
  logic [31:0] in_data5, out_data5;
  logic [4:0]  in_shamt5;
  logic [1:0]  in_mode5;

  logic [31:0] q1[$];
  logic [31:0] q5[$];

  shift_iter #(.W(32), .SPC(1)) dut1 (
    .clock(clk), .reset_n(rst_n1), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_data(in_data1), .in_shamt(in_shamt1), .in_mode(in_mode1), .abort(abort1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1), .busy(busy1)
  );

  shift_iter #(.W(32), .SPC(5)) dut5 (
    .clock(clk), .reset_n(rst_n5), .in_valid(in_valid5), .in_ready(in_ready5),
    .in_data(in_data5), .in_shamt(in_shamt5), .in_mode(in_mode5), .abort(abort5),
    .out_valid(out_valid5), .out_ready(out_ready5), .out_data(out_data5), .busy(busy5)
  );

  function automatic logic [31:0] ref_shift(logic [31:0] d, int s, logic [1:0] m);
    logic [63:0] w;
    case (m)
      2'b00:   return d << s;
      2'b01:   return d >> s;
      2'b10:   return 32'($signed(d) >>> s);
      default: begin
        w = {d, d} << s;
        return w[63:32];
      end
    endcase
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic flag_fail(string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout/unexpected expected normal", name);
  endtask

  // Monitors: pop and compare on every output handshake.
  always @(negedge clk) begin
    if (rst_n1 && out_valid1) begin
      if (q1.size() == 0) flag_fail("m1 spurious out_valid");
      else if (out_ready1) check("m1 data", out_data1, q1.pop_front());
    end
    if (rst_n5 && out_valid5) begin
      if (q5.size() == 0) flag_fail("m5 spurious out_valid");
      else if (out_ready5) check("m5 data", out_data5, q5.pop_front());
    end
  end

  task automatic issue1(logic [31:0] d, int s, logic [1:0] m, logic [31:0] exp);
    int n = 0;
    while (!in_ready1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready1) flag_fail("issue1 ready wait");
    in_valid1 = 1'b1;
    in_data1  = d;
    in_shamt1 = 5'(s);
    in_mode1  = m;
    q1.push_back(exp);
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    in_data1  = $urandom;
    in_shamt1 = 5'($urandom);
  endtask

  task automatic wait_valid1(output int cyc);
    cyc = 0;
    while (!out_valid1 && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
  endtask

  task automatic release1(string nm);
    out_ready1 = 1'b1;
    @(posedge clk); #1;
    out_ready1 = 1'b0;
    check({nm, " ready/valid after handshake"}, {30'd0, in_ready1, out_valid1}, 32'd2);
  endtask

  task automatic run1(string nm, logic [31:0] d, int s, logic [1:0] m, logic [31:0] exp, logic ab);
    int lat;
    abort1 = ab;
    issue1(d, s, m, exp);
    abort1 = 1'b0;
    wait_valid1(lat);
    check({nm, " latency"}, lat, 5);
    release1(nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n1 = 1'b0; in_valid1 = 1'b0; in_data1 = '0; in_shamt1 = '0; in_mode1 = '0;
    abort1 = 1'b0; out_ready1 = 1'b0;
    rst_n5 = 1'b0; in_valid5 = 1'b0; in_data5 = '0; in_shamt5 = '0; in_mode5 = '0;
    abort5 = 1'b0; out_ready5 = 1'b1;
    #2;
    check("reset flags1", {29'd0, in_ready1, out_valid1, busy1}, 32'd4);
    check("reset data1", out_data1, 32'd0);
    check("reset flags5", {29'd0, in_ready5, out_valid5, busy5}, 32'd4);
    repeat (2) @(negedge clk);
    rst_n1 = 1'b1;
    rst_n5 = 1'b1;
    @(posedge clk); #1;

    fork
      begin : directed
        logic [31:0] held;
        int lat;
        run1("sll",   32'h000000FF, 8,  2'b00, 32'h0000FF00, 1'b0);
        run1("sra",   32'h80000000, 4,  2'b10, 32'hF8000000, 1'b0);
        run1("srl",   32'h80000000, 4,  2'b01, 32'h08000000, 1'b0);
        run1("rol",   32'h80000001, 1,  2'b11, 32'h00000003, 1'b1);
        run1("zero",  32'h12345678, 0,  2'b10, 32'h12345678, 1'b0);
        run1("sra31", 32'h80000000, 31, 2'b10, 32'hFFFFFFFF, 1'b0);
        run1("sra31p",32'h7FFFFFFF, 31, 2'b10, 32'h00000000, 1'b0);

        // backpressure
        issue1(32'hA5A5A5A5, 3, 2'b11, 32'h2D2D2D2D);
        wait_valid1(lat);
        check("bp latency", lat, 5);
        held = out_data1;
        for (int i = 0; i < 10; i++) begin
          @(posedge clk); #1;
          check("bp data stable", out_data1, held);
          check("bp valid/ready", {30'd0, out_valid1, in_ready1}, 32'd2);
        end
        release1("bp");

        // abort in the second shift cycle
        issue1(32'h00000005, 3, 2'b00, 32'h00000028);
        @(posedge clk); #1;
        abort1 = 1'b1;
        @(posedge clk); #1;
        abort1 = 1'b0;
        void'(q1.pop_back());
        check("abort idle", {29'd0, busy1, in_ready1, out_valid1}, 32'd2);
        repeat (8) @(posedge clk);
        #1;
        run1("after abort", 32'h00000001, 31, 2'b00, 32'h80000000, 1'b0);

        // asynchronous reset in the middle of an operation
        issue1(32'h00001234, 4, 2'b00, 32'h00012340);
        #2;
        rst_n1 = 1'b0;
        #1;
        check("mid reset flags", {29'd0, in_ready1, out_valid1, busy1}, 32'd4);
        check("mid reset data", out_data1, 32'd0);
        q1.delete();
        @(negedge clk);
        rst_n1 = 1'b1;
        @(posedge clk); #1;
        check("post reset ready", {31'd0, in_ready1}, 32'd1);
        run1("after reset", 32'hFFFF0000, 16, 2'b10, 32'hFFFFFFFF, 1'b0);
      end

      begin : randomized
        int cyc = 0;
        int last_acc = 0;
        int n = 0;
        int s;
        s = $urandom_range(0, 31);
        in_valid5 = 1'b1;
        in_data5  = $urandom;
        in_shamt5 = 5'(s);
        in_mode5  = 2'($urandom_range(0, 3));
        while (n < 200 && cyc < 5000) begin
          if (in_ready5) begin
            q5.push_back(ref_shift(in_data5, s, in_mode5));
            @(posedge clk); #1; cyc++;
            if (n > 0) check("b2b gap", cyc - last_acc, 3);
            last_acc = cyc;
            n++;
            s = (n % 50 == 0) ? 0 : (n % 50 == 1) ? 31 : $urandom_range(0, 31);
            in_data5  = $urandom;
            in_shamt5 = 5'(s);
            in_mode5  = 2'($urandom_range(0, 3));
          end else begin
            @(posedge clk); #1; cyc++;
          end
        end
        in_valid5 = 1'b0;
        if (n < 200) flag_fail("random issue budget");
      end
    join

    repeat (6) @(posedge clk);
    #1;
    check("q1 drained", q1.size(), 32'd0);
    check("q5 drained", q5.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/shift_iter.md
Name: shift_iter

Overview:
- Parametrised multicycle shifter for the processor datapath. It generalises the fixed one-direction shift-by-constant blocks into a single unit.
- Covers any data width and any shift amount, with four modes: logical left, logical right, arithmetic right and rotate left.
- A barrel network is applied a few stages per cycle, trading latency for area. A valid/ready handshake at both ends lets it sit beside the multicycle mult/div units.

Parameters:
- W, 32, data width; power of two, minimum 2.
- SHAMT_W, $clog2(W), shift-amount width; derived, not overridden.
- SPC, 1, barrel stages applied per cycle; legal range 1..SHAMT_W.
- NCYC, ceil(SHAMT_W/SPC), SHIFT-state cycles per operation; derived.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand presented.
- in_ready  out  1  unit can accept an operand.
- in_data  in  W  value to shift.
- in_shamt  in  SHAMT_W  shift amount 0..W-1.
- in_mode  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROL.
- abort  in  1  synchronous cancel of the operation in flight.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- out_data  out  W  shifted result.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE, in_ready=1, out_valid=0, out_data=0, busy=0, internal counter, data, shamt and mode registers all 0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch data, shamt and mode; counter=0; go to SHIFT.
- SHIFT:
  - in_ready=0.
  - Each cycle applies stages k = counter*SPC .. counter*SPC+SPC-1, skipping k>=SHAMT_W.
  - Stage k shifts by 2^k when shamt[k]=1, otherwise passes the value through.
  - Counter increments each cycle. After the cycle with counter==NCYC-1, go to DONE.
- DONE:
  - out_valid=1 and out_data holds the result.
  - out_valid, out_data and in_ready remain stable until out_ready=1.
  - On out_ready: go to IDLE with out_valid=0. out_data keeps its last value.
  - No new operand is accepted in the same cycle as the DONE handshake; in_ready=1 from the following cycle.
- Latency: accept at edge N gives out_valid=1 from edge N+NCYC. With W=32, SPC=1 that is 5 cycles; with SPC=5 it is 1 cycle.
- Mode rules per stage:
  - SLL: zero-fill from the LSB.
  - SRL: zero-fill from the MSB.
  - SRA: fill with the original sign bit, data[W-1] latched at accept.
  - ROL: bits shifted out at the MSB re-enter at the LSB.
- Width and boundary rules:
  - shamt=0 returns in_data unchanged, in all modes, after the full NCYC latency.
  - shamt=W-1 is legal. For SRA it yields all sign bits except bit 0, which equals data[W-1].
- abort:
  - Sampled in SHIFT or DONE: next state is IDLE with out_valid=0 and the result discarded.
  - Ignored in IDLE. If abort and in_valid coincide in IDLE, the operand is accepted.
- Reset asserted mid-operation returns every output to its reset value immediately. No partial result is ever presented.
- in_* values are don't-care outside the accept cycle.

Decomposition:
- Shared package shift_pkg holds:
  - mode localparams MODE_SLL=2'b00, MODE_SRL=2'b01, MODE_SRA=2'b10, MODE_ROL=2'b11;
  - state encoding IDLE, SHIFT, DONE.
- Sub-module shift_stage: combinational, parameters W and K. Ports: in[W], en, mode[2], sign, out[W]. Output is in shifted by 2^K per mode when en=1, else passthrough.
- shift_iter instantiates SPC shift_stage copies in a chain, with stage index selected by the counter through a generate/mux.

Test Plan:
- W=32, SPC=1. SLL 0x000000FF by 8 -> out_data 0x0000FF00, out_valid exactly 5 cycles after accept.
- SRA 0x80000000 by 4 -> 0xF8000000. SRL 0x80000000 by 4 -> 0x08000000. ROL 0x80000001 by 1 -> 0x00000003. shamt=0 on 0x12345678 -> 0x12345678.
- Backpressure: hold out_ready=0 for 10 cycles after DONE -> out_valid stays 1, out_data stable, in_ready=0 throughout. Release -> in_ready=1 on the following cycle.
- abort in the second SHIFT cycle -> IDLE next cycle, out_valid never asserts. The next operand (SLL 0x1 by 31 -> 0x80000000) completes normally.
- reset_n pulsed low mid-SHIFT -> outputs go to reset values asynchronously. After release, in_ready=1 and a fresh SRA 0xFFFF0000 by 16 -> 0xFFFFFFFF.
- W=32, SPC=5: every mode over 200 random data/shamt pairs -> result matches the golden model with 1-cycle latency. Back-to-back operations with out_ready tied high -> one result every 3 cycles.
